// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for a 15-entry register file (r0 hard-wired zero).
// Arbitrates the single write port between the ALU (A) and load (M)
// producers round-robin, registers the winning write, and keeps a
// pending-destination scoreboard that drives the issue-stage hazard stalls.
module regfile_wb_arbiter #(
  parameter int NREG = 15
) (
  input  logic        clk,
  input  logic        reset,
  // ALU producer
  input  logic        a_valid_in,
  input  logic [4:0]  a_addr_in,
  input  logic [31:0] a_data_in,
  output logic        a_ready_out,
  // Load producer
  input  logic        m_valid_in,
  input  logic [4:0]  m_addr_in,
  input  logic [31:0] m_data_in,
  output logic        m_ready_out,
  // Register file write port
  output logic        reg_w_out,
  output logic [4:0]  reg_addr_w_out,
  output logic [31:0] reg_data_w_out,
  // Issue stage
  input  logic        iss_valid_in,
  input  logic [4:0]  iss_addr_in,
  output logic        iss_ready_out,
  input  logic [4:0]  rs_addr_in,
  input  logic [4:0]  rt_addr_in,
  output logic        busy_rs_out,
  output logic        busy_rt_out,
  output logic        addr_err_out
);

  localparam logic [4:0] NREG_ADDR = 5'(NREG);

  // Which producer won the most recent grant; the other one has priority
  // the next time both request.
  typedef enum logic {
    PORT_A = 1'b0,
    PORT_M = 1'b1
  } port_e;

  port_e       last_reg, last_next;

  logic        w_reg, w_next;
  logic [4:0]  addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic        err_reg, err_next;

  logic [NREG:1] pend_reg, pend_next;

  logic        grant_a, grant_m, any_grant;
  logic [4:0]  sel_addr;
  logic [31:0] sel_data;
  logic        sel_in_range, sel_too_high, iss_too_high;

  // One-hot decodes of every address that touches the scoreboard.
  // Addresses 0 and > NREG decode to all-zero, so they never stall,
  // never report busy and never set or clear a pending bit.
  logic [NREG:1] iss_dec, rs_dec, rt_dec, clr_dec, set_dec;

  genvar gi;
  generate
    for (gi = 1; gi <= NREG; gi++) begin : g_pend
      assign iss_dec[gi]   = (iss_addr_in    == 5'(gi));
      assign rs_dec[gi]    = (rs_addr_in     == 5'(gi));
      assign rt_dec[gi]    = (rt_addr_in     == 5'(gi));
      // A committing write retires its destination at the same edge the
      // file captures the data.
      assign clr_dec[gi]   = w_reg & (addr_reg == 5'(gi));
      assign set_dec[gi]   = iss_valid_in & iss_ready_out & iss_dec[gi];
      // A new dispatch to the same register outranks the retiring write.
      assign pend_next[gi] = set_dec[gi] | (pend_reg[gi] & ~clr_dec[gi]);
    end
  endgenerate

  // Hazard outputs depend only on the scoreboard and the issue-stage
  // addresses, never on the write-port registers' outputs.
  assign iss_ready_out = ~|(pend_reg & iss_dec);
  assign busy_rs_out   =  |(pend_reg & rs_dec);
  assign busy_rt_out   =  |(pend_reg & rt_dec);

  // Zero-cycle round-robin grant: a lone requester always wins; on a tie
  // the port that did not win last time goes first.
  always_comb begin
    grant_a = 1'b0;
    grant_m = 1'b0;
    if (a_valid_in && (!m_valid_in || last_reg == PORT_M)) begin
      grant_a = 1'b1;
    end else if (m_valid_in) begin
      grant_m = 1'b1;
    end
  end

  assign a_ready_out = grant_a;
  assign m_ready_out = grant_m;
  assign any_grant   = grant_a | grant_m;

  assign sel_addr     = grant_a ? a_addr_in : m_addr_in;
  assign sel_data     = grant_a ? a_data_in : m_data_in;
  assign sel_in_range = (sel_addr != 5'd0) && (sel_addr <= NREG_ADDR);
  assign sel_too_high = sel_addr > NREG_ADDR;
  assign iss_too_high = iss_addr_in > NREG_ADDR;

  // Next-state for the arbiter pointer, write-port registers and error flag.
  always_comb begin
    last_next = last_reg;
    w_next    = 1'b0;
    addr_next = addr_reg;
    data_next = data_reg;
    err_next  = err_reg;

    if (grant_a) begin
      last_next = PORT_A;
    end else if (grant_m) begin
      last_next = PORT_M;
    end

    // Writes to r0 or beyond the file are consumed silently; the address
    // and data outputs keep showing the last real write.
    if (any_grant && sel_in_range) begin
      w_next    = 1'b1;
      addr_next = sel_addr;
      data_next = sel_data;
    end

    if ((any_grant && sel_too_high) || (iss_valid_in && iss_too_high)) begin
      err_next = 1'b1;
    end
  end

  // State register; reset discards any write in flight and all pending bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= PORT_M;
      w_reg    <= 1'b0;
      addr_reg <= 5'd0;
      data_reg <= 32'd0;
      err_reg  <= 1'b0;
      pend_reg <= '0;
    end else begin
      last_reg <= last_next;
      w_reg    <= w_next;
      addr_reg <= addr_next;
      data_reg <= data_next;
      err_reg  <= err_next;
      pend_reg <= pend_next;
    end
  end

  assign reg_w_out      = w_reg;
  assign reg_addr_w_out = addr_reg;
  assign reg_data_w_out = data_reg;
  assign addr_err_out   = err_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus, a behavioural model
// checked against the DUT every cycle, plus literal spot checks.
module tb_regfile_wb_arbiter;

  localparam int NREG = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid_in, m_valid_in, iss_valid_in;
  logic [4:0]  a_addr_in, m_addr_in, iss_addr_in, rs_addr_in, rt_addr_in;
  logic [31:0] a_data_in, m_data_in;
  logic        a_ready_out, m_ready_out, reg_w_out, iss_ready_out;
  logic        busy_rs_out, busy_rt_out, addr_err_out;
  logic [4:0]  reg_addr_w_out;
  logic [31:0] reg_data_w_out;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREG(NREG)) dut (
    .clk(clk), .reset(reset),
    .a_valid_in(a_valid_in), .a_addr_in(a_addr_in), .a_data_in(a_data_in),
    .a_ready_out(a_ready_out),
    .m_valid_in(m_valid_in), .m_addr_in(m_addr_in), .m_data_in(m_data_in),
    .m_ready_out(m_ready_out),
    .reg_w_out(reg_w_out), .reg_addr_w_out(reg_addr_w_out),
    .reg_data_w_out(reg_data_w_out),
    .iss_valid_in(iss_valid_in), .iss_addr_in(iss_addr_in),
    .iss_ready_out(iss_ready_out),
    .rs_addr_in(rs_addr_in), .rt_addr_in(rt_addr_in),
    .busy_rs_out(busy_rs_out), .busy_rt_out(busy_rt_out),
    .addr_err_out(addr_err_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend_m[r]: destination r awaits its write-back.
  // pref: port favoured in the next tie (0 = A, 1 = M).
  bit          pend_m [1:NREG];
  int          pref;
  bit          mdl_w;
  logic [4:0]  mdl_addr;
  logic [31:0] mdl_data;
  bit          mdl_err;
  bit          model_on = 1'b0;
  int          win;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  function automatic bit pending(input logic [4:0] r);
    int ri;
    ri = int'(r);
    if (ri >= 1 && ri <= NREG) return pend_m[ri];
    return 1'b0;
  endfunction

  // 0 = nobody, 1 = A, 2 = M
  function automatic int winner();
    if (a_valid_in && m_valid_in) return (pref == 0) ? 1 : 2;
    if (a_valid_in) return 1;
    if (m_valid_in) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      model_on <= 1'b1;
      for (int i = 1; i <= NREG; i++) pend_m[i] <= 1'b0;
      pref     <= 0;
      mdl_w    <= 1'b0;
      mdl_addr <= 5'd0;
      mdl_data <= 32'd0;
      mdl_err  <= 1'b0;
    end else if (model_on) begin
      win = winner();
      win_addr = (win == 1) ? a_addr_in : m_addr_in;
      win_data = (win == 1) ? a_data_in : m_data_in;
      mdl_w <= 1'b0;
      if (win != 0) begin
        pref <= (win == 1) ? 1 : 0;
        $display("xfer port=%s addr=%0d data=%h", (win == 1) ? "A" : "M", win_addr, win_data);
        if (int'(win_addr) >= 1 && int'(win_addr) <= NREG) begin
          mdl_w    <= 1'b1;
          mdl_addr <= win_addr;
          mdl_data <= win_data;
        end
        if (int'(win_addr) > NREG) mdl_err <= 1'b1;
      end
      if (iss_valid_in && int'(iss_addr_in) > NREG) mdl_err <= 1'b1;
      for (int i = 1; i <= NREG; i++) begin
        if (iss_valid_in && int'(iss_addr_in) == i && !pend_m[i]) pend_m[i] <= 1'b1;
        else if (mdl_w && int'(mdl_addr) == i) pend_m[i] <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_on) begin
      check("a_ready",   a_ready_out,    winner() == 1);
      check("m_ready",   m_ready_out,    winner() == 2);
      check("reg_w",     reg_w_out,      mdl_w);
      check("reg_addr",  reg_addr_w_out, mdl_addr);
      check("reg_data",  reg_data_w_out, mdl_data);
      check("iss_ready", iss_ready_out,  !pending(iss_addr_in));
      check("busy_rs",   busy_rs_out,    pending(rs_addr_in));
      check("busy_rt",   busy_rt_out,    pending(rt_addr_in));
      check("addr_err",  addr_err_out,   mdl_err);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    a_valid_in = 0; a_addr_in = 0; a_data_in = 0;
    m_valid_in = 0; m_addr_in = 0; m_data_in = 0;
    iss_valid_in = 0; iss_addr_in = 0; rs_addr_in = 0; rt_addr_in = 0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("idle_w", reg_w_out, 0);
    check("idle_addr", reg_addr_w_out, 0);
    check("idle_iss_ready", iss_ready_out, 1);
    check("idle_err", addr_err_out, 0);

    // single A then single M
    tick(); a_valid_in = 1; a_addr_in = 1; a_data_in = 32'hA1;
    @(negedge clk); check("single_a_ready", a_ready_out, 1);
    tick(); a_valid_in = 0; m_valid_in = 1; m_addr_in = 2; m_data_in = 32'hB2;
    @(negedge clk);
    check("single_a_wr_addr", reg_addr_w_out, 1);
    check("single_a_wr_data", reg_data_w_out, 32'hA1);
    check("single_m_ready", m_ready_out, 1);
    tick(); m_valid_in = 0;
    @(negedge clk);
    check("single_m_wr_addr", reg_addr_w_out, 2);
    check("single_m_wr_data", reg_data_w_out, 32'hB2);

    // contention: both valid four cycles, grants A, M, A, M
    tick();
    a_valid_in = 1; a_addr_in = 3; a_data_in = 32'h11111111;
    m_valid_in = 1; m_addr_in = 5; m_data_in = 32'h22222222;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("cont_grant_a", a_ready_out, (k % 2) == 0);
      check("cont_grant_m", m_ready_out, (k % 2) == 1);
      if (k > 0) begin
        check("cont_wr_addr", reg_addr_w_out, ((k - 1) % 2 == 0) ? 32'd3 : 32'd5);
        check("cont_wr_data", reg_data_w_out,
              ((k - 1) % 2 == 0) ? 32'h11111111 + 32'((k - 1) / 2)
                                 : 32'h22222222 + 32'((k - 1) / 2));
      end
      tick();
      if (k % 2 == 0) a_data_in = a_data_in + 1;
      else            m_data_in = m_data_in + 1;
    end
    a_valid_in = 0; m_valid_in = 0;
    @(negedge clk);
    check("cont_last_addr", reg_addr_w_out, 5);
    check("cont_last_data", reg_data_w_out, 32'h22222223);

    // address boundaries: r0, r16, r15
    tick(); a_valid_in = 1; a_addr_in = 0; a_data_in = 32'hDEAD;
    tick(); a_valid_in = 0; m_valid_in = 1; m_addr_in = 16; m_data_in = 32'hBEEF;
    @(negedge clk);
    check("r0_no_write", reg_w_out, 0);
    check("r0_no_err", addr_err_out, 0);
    tick(); m_valid_in = 0; a_valid_in = 1; a_addr_in = 15; a_data_in = 32'h0F0F0F0F;
    @(negedge clk);
    check("r16_no_write", reg_w_out, 0);
    check("r16_err", addr_err_out, 1);
    tick(); a_valid_in = 0;
    @(negedge clk);
    check("r15_write", reg_w_out, 1);
    check("r15_addr", reg_addr_w_out, 15);
    check("r15_data", reg_data_w_out, 32'h0F0F0F0F);
    check("err_sticky", addr_err_out, 1);

    // scoreboard: dispatch r7, stall, commit, release
    tick(); iss_valid_in = 1; iss_addr_in = 7;
    @(negedge clk); check("sb_first_dispatch", iss_ready_out, 1);
    tick(); rs_addr_in = 7; rt_addr_in = 7;
    @(negedge clk);
    check("sb_busy_rs", busy_rs_out, 1);
    check("sb_busy_rt", busy_rt_out, 1);
    check("sb_waw_stall", iss_ready_out, 0);
    tick(); iss_valid_in = 0; m_valid_in = 1; m_addr_in = 7; m_data_in = 32'h77;
    @(negedge clk); check("sb_m_ready", m_ready_out, 1);
    tick(); m_valid_in = 0;
    @(negedge clk);
    check("sb_commit_w", reg_w_out, 1);
    check("sb_commit_addr", reg_addr_w_out, 7);
    check("sb_busy_during_commit", busy_rs_out, 1);
    tick();
    @(negedge clk);
    check("sb_busy_after_commit", busy_rs_out, 0);

    // set/clear collision on r9
    tick(); a_valid_in = 1; a_addr_in = 9; a_data_in = 32'h99; rs_addr_in = 9;
    tick(); a_valid_in = 0; iss_valid_in = 1; iss_addr_in = 9;
    @(negedge clk);
    check("coll_w", reg_w_out, 1);
    check("coll_addr", reg_addr_w_out, 9);
    check("coll_iss_ready", iss_ready_out, 1);
    tick(); iss_valid_in = 0;
    @(negedge clk); check("coll_set_wins", busy_rs_out, 1);

    // reset mid-operation
    tick(); iss_valid_in = 1; iss_addr_in = 2;
    tick(); iss_addr_in = 4;
    tick(); iss_valid_in = 0; a_valid_in = 1; a_addr_in = 2; a_data_in = 32'h22;
    rs_addr_in = 2; rt_addr_in = 4;
    @(negedge clk);
    check("rst_setup_rs", busy_rs_out, 1);
    check("rst_setup_rt", busy_rt_out, 1);
    tick(); reset = 1; a_addr_in = 4; a_data_in = 32'h44;
    m_valid_in = 1; m_addr_in = 6; m_data_in = 32'h66;
    @(negedge clk);
    check("rst_inflight_w", reg_w_out, 1);
    check("rst_cycle_m_turn", m_ready_out, 1);
    tick(); reset = 0; a_valid_in = 0; m_valid_in = 0;
    @(negedge clk);
    check("rst_w_dropped", reg_w_out, 0);
    check("rst_addr", reg_addr_w_out, 0);
    check("rst_busy_rs", busy_rs_out, 0);
    check("rst_busy_rt", busy_rt_out, 0);
    check("rst_err", addr_err_out, 0);
    tick(); a_valid_in = 1; a_addr_in = 1; a_data_in = 32'h5;
    m_valid_in = 1; m_addr_in = 3; m_data_in = 32'h6;
    @(negedge clk);
    check("rst_a_first", a_ready_out, 1);
    check("rst_m_waits", m_ready_out, 0);
    tick(); a_valid_in = 0; m_valid_in = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back controller for the 15-entry register file (registers 1–15, r0 hard-wired zero). It shares the file's single write port between two producers, the ALU result path (A) and the memory-load path (M), using valid/ready handshakes and round-robin arbitration. It registers the winning write onto the file's write port. A pending-destination scoreboard drives the issue stage's hazard stall outputs.

## Interface
Parameters:
- NREG, 15, highest architectural register index; valid addresses are 1..NREG.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- a_valid_in  in  1  ALU producer has a write-back request.
- a_addr_in  in  5  ALU destination register.
- a_data_in  in  32  ALU write data.
- a_ready_out  out  1  ALU request is accepted this cycle.
- m_valid_in  in  1  load producer has a write-back request.
- m_addr_in  in  5  load destination register.
- m_data_in  in  32  load write data.
- m_ready_out  out  1  load request is accepted this cycle.
- reg_w_out  out  1  write enable to the register file.
- reg_addr_w_out  out  5  write address to the register file.
- reg_data_w_out  out  32  write data to the register file.
- iss_valid_in  in  1  issue stage is dispatching an instruction with a destination.
- iss_addr_in  in  5  destination of the dispatched instruction.
- iss_ready_out  out  1  dispatch is allowed (destination is not pending).
- rs_addr_in, rt_addr_in  in  5 each  source registers of the instruction in issue.
- busy_rs_out, busy_rt_out  out  1 each  the corresponding source is pending.
- addr_err_out  out  1  sticky flag: an out-of-range address (> NREG) was seen.

## Operation
Arbitration (combinational grant, registered write):
- The pointer `last` records the last granted port. Reset value is M, so A wins the first contest.
- Only A valid: grant A. Only M valid: grant M. Both valid: grant the port that is not `last`.
- `a_ready_out` / `m_ready_out` equal the grant. A transfer occurs when valid and ready are both high.
- `last` updates on every grant, including single-requester grants.
- A producer must hold valid, addr and data stable until it sees ready.

Write stage:
- A granted request with addr in 1..NREG drives the write outputs on the next cycle: `reg_w_out` = 1, with the granted addr and data.
- A granted request with addr 0 is consumed, and `reg_w_out` = 0 on the next cycle.
- A granted request with addr > NREG is consumed, `reg_w_out` = 0 on the next cycle, and `addr_err_out` is set.
- If no grant occurs, `reg_w_out` = 0 on the next cycle. Address and data outputs hold their previous values.

Scoreboard (`pend[NREG:1]`):
- Set: `iss_valid_in` && `iss_ready_out` && `iss_addr_in` in 1..NREG.
- Clear: `reg_w_out` = 1 clears `pend[reg_addr_w_out]`. The clear takes effect at the same edge the file is written.
- Simultaneous set and clear of the same bit: the set wins.
- `iss_ready_out` = 0 when `iss_addr_in` in 1..NREG and that bit is pending (write-after-write stall); otherwise 1.
  - Address 0 never stalls.
  - An address > NREG never stalls but sets `addr_err_out` when `iss_valid_in` = 1.
- `busy_rs_out` = (rs != 0) && rs ≤ NREG && `pend[rs]`. `busy_rt_out` is the same for rt. Both are combinational from `pend`.

Reset:
- `pend` = 0, `last` = M.
- `reg_w_out` = 0, `reg_addr_w_out` = 0, `reg_data_w_out` = 0, `addr_err_out` = 0.
- Ready and busy outputs follow combinationally from the cleared state, so ready is not gated by reset.
- Reset asserted mid-operation discards any registered write (`reg_w_out` = 0 on the next cycle) and all pending bits. Requests accepted in the reset cycle are lost.

## Timing
- Grant is zero-cycle: ready is valid in the same cycle as valid.
- Write-port latency is 1 cycle from the accepting edge. Throughput is one write per cycle across both ports.
- Both producers continuously valid: grants alternate A, M, A, M. Each port waits at most 1 cycle.
- Scoreboard sequence for a dispatch at edge E0 with commit on the write port at edge Ew:
  - `busy_*` is 1 from after E0 through the cycle ending at Ew.
  - `busy_*` is 0 in the cycle after Ew, when the file already holds the new value.
  - There is no bypass path.
- No combinational path from the `reg_*_out` outputs back to the ready outputs.

## Test plan
- Reset, then idle: `reg_w_out` = 0, all outputs 0 except `iss_ready_out` = 1; A then M single requests granted in order.
- Contention: A (r3 = 0x11111111) and M (r5 = 0x22222222) both valid for 4 cycles, changing data per accept:
  - Grants A, M, A, M.
  - Write port shows r3, r5, r3, r5, one cycle behind each grant.
- Address boundaries:
  - A writes r0: consumed, with no `reg_w_out`.
  - M writes r16: consumed, with no `reg_w_out`, and `addr_err_out` = 1 stays high until reset.
  - Write to r15: committed.
- Scoreboard:
  - Dispatch dst r7. Then `rs_addr_in` = 7 gives `busy_rs_out` = 1, and dispatch to r7 gives `iss_ready_out` = 0.
  - M writes r7. `busy_rs_out` = 0 in the cycle after `reg_w_out` is high for r7.
- Set/clear collision: an untracked write of r9 commits in the same cycle as a dispatch to r9. Result: `pend[9]` = 1.
- Reset mid-operation:
  - Setup: r2 and r4 pending, and a grant to r2 in flight.
  - Assert reset for 1 cycle. `reg_w_out` = 0 on the next cycle, `busy_*` = 0, and the next contest grants A first.
